stroke_replay_buffer: RTL
=========================

STROKE_REPLAY_BUFFER -- requirements
Module: stroke_replay_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning maximum stored points per stroke (power of two).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning log2(DEPTH).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  capture point valid.
REQ-006 i_x, i_y  input  5 each  capture point coordinates.
REQ-007 i_last  input  1  final point of stroke, qualified by i_valid.
REQ-008 o_ready  output  1  capture port accepting; a point transfers when i_valid & o_ready.
REQ-009 o_valid  output  1  replay point valid.
REQ-010 i_ready  input  1  downstream accepting; a replay point transfers when o_valid & i_ready.
REQ-011 o_x, o_y  output  5 each  replayed coordinates.
REQ-012 o_index  output  12  zero-based index of the replayed point within the stroke.
REQ-013 o_last  output  1  replayed point is the final stored point.
REQ-014 o_pass  output  1  0 = length pass, 1 = resample pass.
REQ-015 i_len_valid  input  1  total-length result from the downstream length stage is valid.
REQ-016 i_total_length  input  23  total curve length from the length stage.
REQ-017 o_total_length  output  23  latched total length, stable for the whole resample pass.
REQ-018 o_overflow  output  1  sticky flag: the stroke exceeded DEPTH points.
REQ-019 o_done  output  1  one-cycle pulse after the last resample-pass transfer.

Function
REQ-020 The FSM SHALL have states IDLE, CAPTURE, PASS1, WAIT_LEN and PASS2.
REQ-021 o_ready SHALL be 1 only in IDLE and CAPTURE; i_valid in other states SHALL be ignored.
REQ-022 In IDLE, an accepted point SHALL be written at address 0, clear o_overflow, and enter CAPTURE (or PASS1 if i_last).
REQ-023 Each accepted point SHALL be written at wr_ptr, then wr_ptr SHALL increment.
REQ-024 An accepted point with i_last SHALL set count = stored points and enter PASS1 on the next cycle.
REQ-025 When wr_ptr == DEPTH, further points SHALL be dropped, o_overflow set and count held at DEPTH, with i_last still ending capture.
REQ-026 In PASS1/PASS2, points SHALL replay from address 0 to count-1 in order, with o_index equal to the address.
REQ-027 o_valid SHALL assert the cycle after entering PASS1/PASS2; when o_valid & !i_ready, all replay outputs SHALL hold.
REQ-028 After a transfer, the next point SHALL be presented on the next cycle, with no bubbles while i_ready = 1.
REQ-029 o_last SHALL be 1 exactly when o_index == count-1; a single-point stroke gives o_index 0 with o_last 1.
REQ-030 The o_last transfer in PASS1 SHALL deassert o_valid and enter WAIT_LEN.
REQ-031 In WAIT_LEN, i_len_valid SHALL latch i_total_length into o_total_length and enter PASS2 with o_pass = 1.
REQ-032 i_len_valid outside WAIT_LEN SHALL be ignored.
REQ-033 The o_last transfer in PASS2 SHALL pulse o_done on the following cycle and return to IDLE.
REQ-034 Storage contents SHALL be retained across both passes.
REQ-035 Replay latency from the PASS1 entry cycle to the first o_valid SHALL be exactly 1 cycle.

Reset
REQ-036 Reset SHALL force IDLE and zero wr_ptr, count, replay pointer, o_valid, o_x, o_y, o_index, o_last, o_pass, o_total_length, o_overflow and o_done.
REQ-037 o_ready SHALL be 1 after reset.
REQ-038 Reset asserted mid-pass SHALL abort immediately; the next stroke starts fresh at address 0.
REQ-039 Storage array contents SHALL NOT need reset.

Structure
REQ-040 A shared package SHALL hold the state enum, point coordinate width (5), index width (12), length width (23) and default DEPTH.
REQ-041 One sub-module SHALL be natural: stroke_point_ram, a DEPTH x 10-bit storage with synchronous write and combinational read.

Verification
REQ-042 3 points (1,2),(4,6),(7,9) with i_last on the third, i_ready = 1 -> PASS1 emits indices 0,1,2 on consecutive cycles with o_pass = 0 and o_last on index 2.
REQ-043 Same 3-point stroke, then i_len_valid with length 25 in WAIT_LEN -> o_total_length = 25; PASS2 replays the identical 3 points with o_pass = 1; o_done pulses once; state returns to IDLE.
REQ-044 i_ready held low for 4 cycles at index 1 -> o_x/o_y/o_index stay (4,6)/1 and no point is skipped or duplicated.
REQ-045 DEPTH+3 points with i_last on the final one -> o_overflow = 1, replay stops at index DEPTH-1 with o_last, and the next stroke clears o_overflow.
REQ-046 Single point (31,0) with i_last -> each pass emits index 0 with o_last = 1.
REQ-047 i_rst asserted during PASS2 at index 1 -> all outputs zero and o_ready = 1; a new 2-point stroke replays correctly from index 0.

Source files
------------

// File: rtl/stroke_replay_buffer_pkg.sv
// Shared types and widths for the stroke replay buffer.
package stroke_replay_buffer_pkg;

   localparam int COORD_W        = 5;
   localparam int POINT_W        = 2 * COORD_W;
   localparam int INDEX_W        = 12;
   localparam int LEN_W          = 23;
   localparam int DEFAULT_DEPTH  = 256;
   localparam int DEFAULT_ADDR_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_PASS1,
      ST_WAIT_LEN,
      ST_PASS2
   } state_t;

   // Storage word layout: x in the upper half, y in the lower half.
   function automatic logic [POINT_W-1:0] pack_point(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
      return {x, y};
   endfunction

endpackage

// File: rtl/stroke_point_ram.sv
// Point storage: synchronous write, combinational read, no reset on contents.
module stroke_point_ram #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stroke_replay_buffer.sv
// Captures one pen stroke, then replays it twice: a length pass and a
// resample pass that carries the total length reported by the length stage.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | waiting for the first point of a stroke (written at addr 0)
// ST_CAPTURE  | storing points until i_last; excess points are dropped
// ST_PASS1    | replaying stored points for the length pass (o_pass = 0)
// ST_WAIT_LEN | waiting for the total length from the downstream stage
// ST_PASS2    | replaying stored points for the resample pass (o_pass = 1)
module stroke_replay_buffer
   import stroke_replay_buffer_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   input  logic               i_last,
   output logic               o_ready,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic [INDEX_W-1:0] o_index,
   output logic               o_last,
   output logic               o_pass,
   input  logic               i_len_valid,
   input  logic [LEN_W-1:0]   i_total_length,
   output logic [LEN_W-1:0]   o_total_length,
   output logic               o_overflow,
   output logic               o_done
);

   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t state, next_state;

   // Pointers are one bit wider than the address so they can reach DEPTH.
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   last_idx;
   logic              accept;
   logic              xfer;
   logic              full;
   logic              in_pass;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [POINT_W-1:0] ram_rdata;
   logic              advance;
   logic              finish;

   assign o_ready  = (state == ST_IDLE) || (state == ST_CAPTURE);
   assign accept   = i_valid & o_ready;
   assign xfer     = o_valid & i_ready;
   assign full     = wr_ptr[ADDR_W];
   assign in_pass  = (state == ST_PASS1) || (state == ST_PASS2);
   assign last_idx = count - PTR_ONE;

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      next_state = state;
      ram_we     = 1'b0;
      ram_waddr  = wr_ptr[ADDR_W-1:0];
      advance    = 1'b0;
      finish     = 1'b0;
      case (state)
         ST_IDLE: begin
            ram_waddr = '0;
            if (accept) begin
               ram_we     = 1'b1;
               next_state = i_last ? ST_PASS1 : ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (accept) begin
               ram_we = !full;
               if (i_last) begin
                  next_state = ST_PASS1;
               end
            end
         end
         ST_PASS1, ST_PASS2: begin
            // Present a point on pass entry (o_valid low) or after a
            // non-final transfer; a final transfer closes the pass.
            advance = !o_valid || (i_ready && !o_last);
            finish  = xfer && o_last;
            if (finish) begin
               next_state = (state == ST_PASS1) ? ST_WAIT_LEN : ST_IDLE;
            end
         end
         ST_WAIT_LEN: begin
            if (i_len_valid) begin
               next_state = ST_PASS2;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Capture bookkeeping: write pointer, stored count and overflow flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else if (accept) begin
         if (state == ST_IDLE) begin
            wr_ptr     <= PTR_ONE;
            o_overflow <= 1'b0;
            if (i_last) begin
               count <= PTR_ONE;
            end
         end else begin
            if (full) begin
               o_overflow <= 1'b1;
            end else begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (i_last) begin
               count <= full ? wr_ptr : wr_ptr + PTR_ONE;
            end
         end
      end
   end

   // Replay outputs, pass flag, latched length and done pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_ptr         <= '0;
         o_valid        <= 1'b0;
         o_x            <= '0;
         o_y            <= '0;
         o_index        <= '0;
         o_last         <= 1'b0;
         o_pass         <= 1'b0;
         o_total_length <= '0;
         o_done         <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (advance) begin
            o_valid <= 1'b1;
            o_x     <= ram_rdata[POINT_W-1:COORD_W];
            o_y     <= ram_rdata[COORD_W-1:0];
            o_index <= INDEX_W'(rd_ptr);
            o_last  <= (rd_ptr == last_idx);
            rd_ptr  <= rd_ptr + PTR_ONE;
         end else if (finish) begin
            // rd_ptr returns to 0 so the next pass starts at address 0.
            o_valid <= 1'b0;
            rd_ptr  <= '0;
            if (state == ST_PASS2) begin
               o_done <= 1'b1;
               o_pass <= 1'b0;
            end
         end
         if ((state == ST_WAIT_LEN) && i_len_valid) begin
            o_total_length <= i_total_length;
            o_pass         <= 1'b1;
         end
      end
   end

   stroke_point_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (POINT_W)
   ) u_point_ram (
      .clk     (i_clk),
      .wr_en   (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (pack_point(i_x, i_y)),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (ram_rdata)
   );

endmodule
